// File: rtl/arbiter_types.sv
// Types and constants shared by the memory arbiter and the cache blocks around it.
package arbiter_types;

  localparam int LINE_OFFSET_BITS = 5;
  localparam int LINE_W_DEFAULT   = 256;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one physical-memory line port between the icache miss path and the dcache
// miss/writeback path. The data side has priority, and a streak counter bounds how long I can starve.
module mem_arbiter
  import arbiter_types::*;
#(
  parameter int LINE_W       = LINE_W_DEFAULT,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [31:0]       i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int STREAK_W = 4;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  arb_state_t          state, state_next;
  logic [STREAK_W-1:0] streak;
  logic                d_req;
  logic                grant_i, grant_d;
  logic [31:0]         i_line_addr, d_line_addr;

  // Line offset bits never reach memory.
  logic unused_offset;
  assign unused_offset = ^{i_addr[LINE_OFFSET_BITS-1:0], d_addr[LINE_OFFSET_BITS-1:0]};

  assign d_req       = d_read | d_write;
  assign i_line_addr = {i_addr[31:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
  assign d_line_addr = {d_addr[31:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    i_rdata    = '0;
    d_rdata    = '0;
    unique case (state)
      IDLE: begin
        if (d_req && !(i_read && streak == STREAK_MAX)) begin
          grant_d    = 1'b1;
          state_next = SERVE_D;
        end else if (i_read) begin
          grant_i    = 1'b1;
          state_next = SERVE_I;
        end
      end
      SERVE_I: begin
        if (pmem_resp) begin
          i_resp     = 1'b1;
          i_rdata    = pmem_rdata;
          state_next = IDLE;
        end
      end
      SERVE_D: begin
        if (pmem_resp) begin
          d_resp     = 1'b1;
          // A writeback completion carries no line data back.
          d_rdata    = pmem_read ? pmem_rdata : '0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      streak     <= '0;
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
      pmem_addr  <= '0;
      pmem_wdata <= '0;
    end else begin
      state <= state_next;
      if (grant_i) begin
        pmem_read  <= 1'b1;
        pmem_write <= 1'b0;
        pmem_addr  <= i_line_addr;
        streak     <= '0;
      end else if (grant_d) begin
        // Write wins over a simultaneous read; the held read is granted afterwards.
        pmem_read  <= ~d_write;
        pmem_write <= d_write;
        pmem_addr  <= d_line_addr;
        if (d_write) pmem_wdata <= d_wdata;
        if (!i_read)                streak <= '0;
        else if (streak != STREAK_MAX) streak <= streak + 1'b1;
      end else if (state != IDLE && pmem_resp) begin
        pmem_read  <= 1'b0;
        pmem_write <= 1'b0;
      end
    end
  end

endmodule
